// File: rtl/sec_timer_ctrl.sv
// sec_timer_ctrl: one-second countdown timer with a two-digit BCD display (00..59).
//
// A prescaler divides clk by TICK_DIV to form one-second steps. The FSM
// (IDLE/RUN/PAUSE/DONE) is driven by three level-sampled commands, with
// priority clear > stop > start.
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   res    - synchronous active-high reset, overrides every command
//   start  - load-and-run from IDLE/DONE, resume from PAUSE
//   stop   - pause the countdown while in RUN
//   clear  - abort to IDLE with the digits at 00
//   preset - countdown start value in binary seconds, saturated to 59 on load
//   s_num  - BCD seconds-units digit (0..9)
//   s_ten  - BCD seconds-tens digit (0..5)
//   tick   - registered one-cycle pulse after each one-second decrement
//   done   - registered one-cycle pulse when the count reaches 00
//   state  - FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
module sec_timer_ctrl #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic [5:0] preset,
  output logic [3:0] s_num,
  output logic [2:0] s_ten,
  output logic       tick,
  output logic       done,
  output logic [1:0] state
);

  localparam int unsigned PresW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e             state_q;
  logic [PresW-1:0]   presc_q;
  logic [3:0]         num_q;
  logic [2:0]         ten_q;
  logic               tick_q;
  logic               done_q;

  logic [5:0] sat;
  logic [2:0] load_ten;
  logic [3:0] load_num;
  logic       load_zero;
  logic [2:0] dec_ten;
  logic [3:0] dec_num;
  logic       dec_zero;
  logic       wrap;

  // Load path: saturate the binary preset, then split it into BCD digits.
  always_comb begin
    sat       = (preset > 6'd59) ? 6'd59 : preset;
    load_ten  = 3'(sat / 6'd10);
    load_num  = 4'(sat % 6'd10);
    load_zero = (sat == 6'd0);
  end

  // Decrement path: units borrow from tens when they are at 0.
  always_comb begin
    if (num_q == 4'd0) begin
      dec_num = 4'd9;
      dec_ten = ten_q - 3'd1;
    end else begin
      dec_num = num_q - 4'd1;
      dec_ten = ten_q;
    end
    dec_zero = (dec_ten == 3'd0) && (dec_num == 4'd0);
    wrap     = (presc_q == PresMax);
  end

  always_ff @(posedge clk) begin
    // Pulses default low; set only on the edges that produce them.
    tick_q <= 1'b0;
    done_q <= 1'b0;
    if (res || clear) begin
      state_q <= StIdle;
      presc_q <= '0;
      num_q   <= 4'd0;
      ten_q   <= 3'd0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (!stop && start) begin
            ten_q   <= load_ten;
            num_q   <= load_num;
            presc_q <= '0;
            state_q <= load_zero ? StDone : StRun;
            done_q  <= load_zero;
          end
        end
        StRun: begin
          if (wrap) begin
            // A decrement edge completes even when stop arrives on it.
            presc_q <= '0;
            ten_q   <= dec_ten;
            num_q   <= dec_num;
            tick_q  <= 1'b1;
            if (dec_zero) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else if (stop) begin
              state_q <= StPause;
            end
          end else if (stop) begin
            state_q <= StPause;
          end else begin
            presc_q <= presc_q + PresW'(1);
          end
        end
        StPause: begin
          // Resume keeps the frozen prescaler and digits.
          if (!stop && start) begin
            state_q <= StRun;
          end
        end
      endcase
    end
  end

  assign s_num = num_q;
  assign s_ten = ten_q;
  assign tick  = tick_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_sec_timer_ctrl.sv
// Directed bench for sec_timer_ctrl with TICK_DIV=4. Inputs change and outputs
// are sampled on the falling edge, so each cyc(1) covers exactly one rising edge.
module tb_sec_timer_ctrl;

  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       res;
  logic       start;
  logic       stop;
  logic       clear;
  logic [5:0] preset;
  logic [3:0] s_num;
  logic [2:0] s_ten;
  logic       tick;
  logic       done;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sec_timer_ctrl #(.TICK_DIV(TD)) dut (
    .clk    (clk),
    .res    (res),
    .start  (start),
    .stop   (stop),
    .clear  (clear),
    .preset (preset),
    .s_num  (s_num),
    .s_ten  (s_ten),
    .tick   (tick),
    .done   (done),
    .state  (state)
  );

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Full output snapshot: state, tens, units, tick, done.
  task automatic chk_all(input string tag, input logic [1:0] st, input logic [2:0] ten,
                         input logic [3:0] num, input logic tk, input logic dn);
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_ten"},   32'(s_ten), 32'(ten));
    chk({tag, "_num"},   32'(s_num), 32'(num));
    chk({tag, "_tick"},  32'(tick),  32'(tk));
    chk({tag, "_done"},  32'(done),  32'(dn));
  endtask

  initial begin
    res = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; preset = 6'd0;
    @(negedge clk);
    cyc(2);
    chk_all("reset", 2'b00, 3'd0, 4'd0, 1'b0, 1'b0);
    res = 1'b0;
    cyc(2);
    chk_all("idle_after_reset", 2'b00, 3'd0, 4'd0, 1'b0, 1'b0);

    // preset=3: 03 after load, one second per 4 cycles, done with the last tick.
    preset = 6'd3; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_all("p3_load", 2'b01, 3'd0, 4'd3, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      chk_all($sformatf("p3_k%0d", k), (k == 12) ? 2'b11 : 2'b01, 3'd0,
              4'(3 - k / 4), ((k % 4) == 0), (k == 12));
    end
    cyc(1);
    chk_all("p3_after_done", 2'b11, 3'd0, 4'd0, 1'b0, 1'b0);

    // preset=10 loads from DONE, then borrows to 09.
    preset = 6'd10; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_all("p10_load", 2'b01, 3'd1, 4'd0, 1'b0, 1'b0);
    cyc(3);
    chk_all("p10_hold", 2'b01, 3'd1, 4'd0, 1'b0, 1'b0);
    cyc(1);
    chk_all("p10_borrow", 2'b01, 3'd0, 4'd9, 1'b1, 1'b0);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk_all("p10_clear", 2'b00, 3'd0, 4'd0, 1'b0, 1'b0);

    // preset=63 saturates to 59.
    preset = 6'd63; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_all("p63_load", 2'b01, 3'd5, 4'd9, 1'b0, 1'b0);
    cyc(4);
    chk_all("p63_dec", 2'b01, 3'd5, 4'd8, 1'b1, 1'b0);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;

    // Pause/resume: prescaler freezes at 2, so the next decrement is 2 cycles after resume.
    preset = 6'd5; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_all("p5_load", 2'b01, 3'd0, 4'd5, 1'b0, 1'b0);
    cyc(6);
    chk_all("p5_run6", 2'b01, 3'd0, 4'd4, 1'b0, 1'b0);
    stop = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      chk_all($sformatf("pause_%0d", k), 2'b10, 3'd0, 4'd4, 1'b0, 1'b0);
    end
    stop = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_all("resume", 2'b01, 3'd0, 4'd4, 1'b0, 1'b0);
    cyc(1);
    chk_all("resume_1", 2'b01, 3'd0, 4'd4, 1'b0, 1'b0);
    cyc(1);
    chk_all("resume_dec", 2'b01, 3'd0, 4'd3, 1'b1, 1'b0);

    // clear beats stop and start together.
    clear = 1'b1; stop = 1'b1; start = 1'b1;
    cyc(1);
    clear = 1'b0; stop = 1'b0; start = 1'b0;
    chk_all("clr_all", 2'b00, 3'd0, 4'd0, 1'b0, 1'b0);
    cyc(1);
    chk_all("clr_all_1", 2'b00, 3'd0, 4'd0, 1'b0, 1'b0);

    // preset=0 goes straight to DONE with a single done pulse and no tick.
    preset = 6'd0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_all("p0_load", 2'b11, 3'd0, 4'd0, 1'b0, 1'b1);
    cyc(1);
    chk_all("p0_after", 2'b11, 3'd0, 4'd0, 1'b0, 1'b0);

    // stop landing on a decrement edge: decrement and tick still happen, then PAUSE.
    preset = 6'd2; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk_all("stop_on_dec", 2'b10, 3'd0, 4'd1, 1'b1, 1'b0);
    cyc(1);
    chk_all("stop_on_dec_1", 2'b10, 3'd0, 4'd1, 1'b0, 1'b0);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;

    // res mid-RUN at 07, on what would be a decrement edge: no tick/done.
    preset = 6'd9; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(8);
    chk_all("p9_at07", 2'b01, 3'd0, 4'd7, 1'b1, 1'b0);
    cyc(3);
    res = 1'b1;
    cyc(1);
    res = 1'b0;
    chk_all("res_mid_run", 2'b00, 3'd0, 4'd0, 1'b0, 1'b0);
    cyc(3);
    chk_all("res_stay_idle", 2'b00, 3'd0, 4'd0, 1'b0, 1'b0);
    preset = 6'd2; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_all("reload", 2'b01, 3'd0, 4'd2, 1'b0, 1'b0);
    cyc(4);
    chk_all("reload_dec", 2'b01, 3'd0, 4'd1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
